uc_mmio_responder: RTL and testbench

Synthesizable responder for the dCache uncacheable read and write memory interfaces. It is the far end of the mem_req_uc_read and mem_req_uc_write channels. It hosts a small memory-mapped register window used by simulation and FPGA bring-up: a tohost/exit register, a console byte port and scratch registers. It replaces the behavioural L2 on those two channels and returns responses in hpdcache order: single outstanding request per channel.

---
 rtl/uc_mmio_pkg.sv | 25 ++
 rtl/uc_mmio_regfile.sv | 63 ++++++
 rtl/uc_mmio_responder.sv | 194 +++++++++++++++++++
 tb/tb_uc_mmio_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_mmio_pkg.sv
// Shared types for the uncacheable MMIO responder.
// Commands, register indices and channel FSM states.
package uc_mmio_pkg;

  typedef enum logic [1:0] {
    UC_CMD_READ   = 2'd0,
    UC_CMD_WRITE  = 2'd1,
    UC_CMD_ATOMIC = 2'd2
  } uc_cmd_e;

  localparam int unsigned TOHOST_IDX  = 0;
  localparam int unsigned CONSOLE_IDX = 1;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

endpackage

// File: rtl/uc_mmio_regfile.sv
// MMIO register window: byte-enable writes, combinational read,
// tohost exit latch and console byte pulse.
module uc_mmio_regfile
  import uc_mmio_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [63:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [63:0]      wr_data,
  input  logic [7:0]       wr_be,
  output logic             test_done,
  output logic [62:0]      exit_code,
  output logic             console_valid,
  output logic [7:0]       console_byte
);

  logic [63:0] regs [NUM_REGS];
  logic [63:0] bmask;
  logic        tohost_hit;
  logic        console_hit;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < 8; b++) begin
      bmask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  assign rd_data     = regs[rd_idx];
  assign tohost_hit  = we && (wr_idx == IDX_W'(TOHOST_IDX)) && wr_be[0];
  assign console_hit = we && (wr_idx == IDX_W'(CONSOLE_IDX)) && wr_be[0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      test_done     <= 1'b0;
      exit_code     <= '0;
      console_valid <= 1'b0;
      console_byte  <= '0;
    end else begin
      if (we) begin
        regs[wr_idx] <= (regs[wr_idx] & ~bmask) | (wr_data & bmask);
      end
      if (tohost_hit && wr_data[0]) begin
        test_done <= 1'b1;
        exit_code <= wr_data[63:1];
      end
      console_valid <= console_hit;
      if (console_hit) begin
        console_byte <= wr_data[7:0];
      end
    end
  end

endmodule

// File: rtl/uc_mmio_responder.sv
// Far end of the dCache uncacheable read/write channels.
// Define UC_MMIO_RAND_STALL_EN to gate request/data readies with an LFSR.
module uc_mmio_responder
  import uc_mmio_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 40,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 40'h00_4000_0000,
  parameter int unsigned            NUM_REGS   = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [7:0]              rd_req_len_i,
  input  logic [2:0]              rd_req_size_i,
  input  logic [ID_WIDTH-1:0]     rd_req_id_i,
  input  logic [1:0]              rd_req_command_i,
  output logic                    rd_resp_valid_o,
  input  logic                    rd_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_resp_data_o,
  output logic [ID_WIDTH-1:0]     rd_resp_id_o,
  output logic                    rd_resp_error_o,
  output logic                    rd_resp_last_o,
  input  logic                    wr_req_valid_i,
  output logic                    wr_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [7:0]              wr_req_len_i,
  input  logic [2:0]              wr_req_size_i,
  input  logic [ID_WIDTH-1:0]     wr_req_id_i,
  input  logic [1:0]              wr_req_command_i,
  input  logic                    wr_data_valid_i,
  output logic                    wr_data_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic                    wr_last_i,
  output logic                    wr_resp_valid_o,
  input  logic                    wr_resp_ready_i,
  output logic [ID_WIDTH-1:0]     wr_resp_id_o,
  output logic                    wr_resp_error_o,
  output logic                    wr_resp_is_atomic_o,
  output logic                    test_done_o,
  output logic [62:0]             exit_code_o,
  output logic                    console_valid_o,
  output logic [7:0]              console_byte_o
);

  localparam int unsigned OFF_W = $clog2(NUM_REGS * 8);
  localparam int unsigned IDX_W = OFF_W - 3;

  rd_state_e        rd_state;
  wr_state_e        wr_state;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_err_q;
  logic [63:0]      rf_rdata;
  logic             rd_bad;
  logic             wr_bad;
  logic             wr_commit;
  logic             go;

  function automatic logic req_bad(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            cmd,
    input uc_cmd_e               want
  );
    logic [3:0] m;
    m = (4'd1 << size[1:0]) - 4'd1;
    return (a[ADDR_WIDTH-1:OFF_W] != BASE_ADDR[ADDR_WIDTH-1:OFF_W])
        || (len != 8'd0)
        || size[2]
        || (|(a[2:0] & m[2:0]))
        || (cmd != 2'(want));
  endfunction

`ifdef UC_MMIO_RAND_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci taps 16,14,13,11 in right-shift form
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign go = lfsr[0];
`else
  assign go = 1'b1;
`endif

  assign rd_bad = req_bad(rd_req_addr_i, rd_req_len_i, rd_req_size_i,
                          rd_req_command_i, UC_CMD_READ);
  assign wr_bad = req_bad(wr_req_addr_i, wr_req_len_i, wr_req_size_i,
                          wr_req_command_i, UC_CMD_WRITE);

  assign rd_req_ready_o  = (rd_state == RD_IDLE) && go;
  assign wr_req_ready_o  = (wr_state == WR_IDLE) && go;
  assign wr_data_ready_o = (wr_state == WR_DATA) && go;
  assign rd_resp_last_o  = rd_resp_valid_o;

  assign wr_commit = (wr_state == WR_DATA) && wr_data_valid_i
                  && wr_data_ready_o && wr_last_i && !wr_err_q;

  uc_mmio_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .rd_idx        (rd_req_addr_i[OFF_W-1:3]),
    .rd_data       (rf_rdata),
    .we            (wr_commit),
    .wr_idx        (wr_idx_q),
    .wr_data       (wr_data_i),
    .wr_be         (wr_be_i),
    .test_done     (test_done_o),
    .exit_code     (exit_code_o),
    .console_valid (console_valid_o),
    .console_byte  (console_byte_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_state        <= RD_IDLE;
      rd_resp_valid_o <= 1'b0;
      rd_resp_data_o  <= '0;
      rd_resp_id_o    <= '0;
      rd_resp_error_o <= 1'b0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (rd_req_valid_i && rd_req_ready_o) begin
            rd_state        <= RD_RESP;
            rd_resp_valid_o <= 1'b1;
            rd_resp_id_o    <= rd_req_id_i;
            rd_resp_error_o <= rd_bad;
            rd_resp_data_o  <= rd_bad ? '0 : rf_rdata;
          end
        end
        RD_RESP: begin
          if (rd_resp_ready_i) begin
            rd_state        <= RD_IDLE;
            rd_resp_valid_o <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_state            <= WR_IDLE;
      wr_idx_q            <= '0;
      wr_err_q            <= 1'b0;
      wr_resp_valid_o     <= 1'b0;
      wr_resp_id_o        <= '0;
      wr_resp_error_o     <= 1'b0;
      wr_resp_is_atomic_o <= 1'b0;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          if (wr_req_valid_i && wr_req_ready_o) begin
            wr_state            <= WR_DATA;
            wr_idx_q            <= wr_req_addr_i[OFF_W-1:3];
            wr_err_q            <= wr_bad;
            wr_resp_id_o        <= wr_req_id_i;
            wr_resp_is_atomic_o <= (wr_req_command_i == UC_CMD_ATOMIC);
          end
        end
        WR_DATA: begin
          if (wr_data_valid_i && wr_data_ready_o) begin
            if (wr_last_i) begin
              wr_state        <= WR_RESP;
              wr_resp_valid_o <= 1'b1;
              wr_resp_error_o <= wr_err_q;
            end else begin
              // extra beats are drained and poison the response
              wr_err_q <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (wr_resp_ready_i) begin
            wr_state        <= WR_IDLE;
            wr_resp_valid_o <= 1'b0;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_mmio_responder.sv
// Randomized bench for uc_mmio_responder against a register-window model.
// Define UC_MMIO_RAND_STALL_EN to exercise ready backpressure.
module tb_uc_mmio_responder;

  localparam logic [39:0] BASE = 40'h00_4000_0000;
  localparam int TMO = 200;
`ifdef UC_MMIO_RAND_STALL_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 300;
`endif

  logic        tb_clk = 1'b0;
  logic        tb_rstn = 1'b0;
  logic        rd_req_valid_i = 1'b0;
  logic        rd_req_ready_o;
  logic [39:0] rd_req_addr_i = '0;
  logic [7:0]  rd_req_len_i = '0;
  logic [2:0]  rd_req_size_i = '0;
  logic [3:0]  rd_req_id_i = '0;
  logic [1:0]  rd_req_command_i = '0;
  logic        rd_resp_valid_o;
  logic        rd_resp_ready_i = 1'b0;
  logic [63:0] rd_resp_data_o;
  logic [3:0]  rd_resp_id_o;
  logic        rd_resp_error_o;
  logic        rd_resp_last_o;
  logic        wr_req_valid_i = 1'b0;
  logic        wr_req_ready_o;
  logic [39:0] wr_req_addr_i = '0;
  logic [7:0]  wr_req_len_i = '0;
  logic [2:0]  wr_req_size_i = '0;
  logic [3:0]  wr_req_id_i = '0;
  logic [1:0]  wr_req_command_i = '0;
  logic        wr_data_valid_i = 1'b0;
  logic        wr_data_ready_o;
  logic [63:0] wr_data_i = '0;
  logic [7:0]  wr_be_i = '0;
  logic        wr_last_i = 1'b0;
  logic        wr_resp_valid_o;
  logic        wr_resp_ready_i = 1'b0;
  logic [3:0]  wr_resp_id_o;
  logic        wr_resp_error_o;
  logic        wr_resp_is_atomic_o;
  logic        test_done_o;
  logic [62:0] exit_code_o;
  logic        console_valid_o;
  logic [7:0]  console_byte_o;

  int n_checks = 0;
  int n_errors = 0;
  int cons_cnt = 0;
  logic [7:0]  cons_byte = '0;
  logic [63:0] mregs [8];
  logic        m_done;
  logic [62:0] m_exit;

  always #5 tb_clk = ~tb_clk;

  uc_mmio_responder dut (
    .clk_i               (tb_clk),
    .rstn_i              (tb_rstn),
    .rd_req_valid_i      (rd_req_valid_i),
    .rd_req_ready_o      (rd_req_ready_o),
    .rd_req_addr_i       (rd_req_addr_i),
    .rd_req_len_i        (rd_req_len_i),
    .rd_req_size_i       (rd_req_size_i),
    .rd_req_id_i         (rd_req_id_i),
    .rd_req_command_i    (rd_req_command_i),
    .rd_resp_valid_o     (rd_resp_valid_o),
    .rd_resp_ready_i     (rd_resp_ready_i),
    .rd_resp_data_o      (rd_resp_data_o),
    .rd_resp_id_o        (rd_resp_id_o),
    .rd_resp_error_o     (rd_resp_error_o),
    .rd_resp_last_o      (rd_resp_last_o),
    .wr_req_valid_i      (wr_req_valid_i),
    .wr_req_ready_o      (wr_req_ready_o),
    .wr_req_addr_i       (wr_req_addr_i),
    .wr_req_len_i        (wr_req_len_i),
    .wr_req_size_i       (wr_req_size_i),
    .wr_req_id_i         (wr_req_id_i),
    .wr_req_command_i    (wr_req_command_i),
    .wr_data_valid_i     (wr_data_valid_i),
    .wr_data_ready_o     (wr_data_ready_o),
    .wr_data_i           (wr_data_i),
    .wr_be_i             (wr_be_i),
    .wr_last_i           (wr_last_i),
    .wr_resp_valid_o     (wr_resp_valid_o),
    .wr_resp_ready_i     (wr_resp_ready_i),
    .wr_resp_id_o        (wr_resp_id_o),
    .wr_resp_error_o     (wr_resp_error_o),
    .wr_resp_is_atomic_o (wr_resp_is_atomic_o),
    .test_done_o         (test_done_o),
    .exit_code_o         (exit_code_o),
    .console_valid_o     (console_valid_o),
    .console_byte_o      (console_byte_o)
  );

  always @(negedge tb_clk) begin
    if (console_valid_o) begin
      cons_cnt  = cons_cnt + 1;
      cons_byte = console_byte_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_bad(input logic [39:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] cmd,
                               input logic [1:0] want);
    if (a < BASE || a >= BASE + 40'd64) return 1'b1;
    if (len != 0 || size > 3) return 1'b1;
    if (a % (40'd1 << size) != 0) return 1'b1;
    return cmd != want;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    m_done = 1'b0;
    m_exit = '0;
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic rd_txn(input logic [39:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] cmd,
                        input logic [3:0] id, input int hold,
                        input string tag);
    logic        bad;
    logic [63:0] exp;
    int          n;
    bad = m_bad(a, len, size, cmd, 2'd0);
    exp = bad ? 64'd0 : mregs[(a - BASE) / 8];
    rd_req_addr_i    = a;
    rd_req_len_i     = len;
    rd_req_size_i    = size;
    rd_req_command_i = cmd;
    rd_req_id_i      = id;
    rd_req_valid_i   = 1'b1;
    n = 0;
    while (!rd_req_ready_o && n < TMO) begin
      step();
      n++;
    end
    chk({tag, ".rrdy"}, 64'(rd_req_ready_o), 64'd1);
    step();
    rd_req_valid_i = 1'b0;
    chk({tag, ".lat"}, 64'(rd_resp_valid_o), 64'd1);
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, ".hvr"}, 64'({rd_resp_valid_o, rd_req_ready_o}), 64'd2);
      chk({tag, ".hdat"}, rd_resp_data_o, exp);
    end
    chk({tag, ".data"}, rd_resp_data_o, exp);
    chk({tag, ".id"}, 64'(rd_resp_id_o), 64'(id));
    chk({tag, ".err"}, 64'({rd_resp_error_o, rd_resp_last_o}),
        64'({bad, 1'b1}));
    rd_resp_ready_i = 1'b1;
    step();
    rd_resp_ready_i = 1'b0;
    chk({tag, ".vdrop"}, 64'(rd_resp_valid_o), 64'd0);
  endtask

  task automatic wr_txn(input logic [39:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] cmd,
                        input logic [3:0] id, input logic [63:0] data,
                        input logic [7:0] be, input int beats,
                        input int hold, input string tag);
    logic bad;
    int   n;
    int   c0;
    int   idx;
    logic cons_exp;
    bad = m_bad(a, len, size, cmd, 2'd1) || beats != 1;
    idx = int'((a - BASE) / 8);
    c0  = cons_cnt;
    cons_exp = 1'b0;
    wr_req_addr_i    = a;
    wr_req_len_i     = len;
    wr_req_size_i    = size;
    wr_req_command_i = cmd;
    wr_req_id_i      = id;
    wr_req_valid_i   = 1'b1;
    n = 0;
    while (!wr_req_ready_o && n < TMO) begin
      step();
      n++;
    end
    chk({tag, ".wrdy"}, 64'(wr_req_ready_o), 64'd1);
    step();
    wr_req_valid_i = 1'b0;
    for (int b = 0; b < beats; b++) begin
      wr_data_i       = (b == 0) ? data : {$urandom, $urandom};
      wr_be_i         = be;
      wr_last_i       = (b == beats - 1);
      wr_data_valid_i = 1'b1;
      n = 0;
      while (!wr_data_ready_o && n < TMO) begin
        step();
        n++;
      end
      chk({tag, ".drdy"}, 64'(wr_data_ready_o), 64'd1);
      step();
      wr_data_valid_i = 1'b0;
      wr_last_i       = 1'b0;
    end
    if (!bad) begin
      for (int k = 0; k < 8; k++)
        if (be[k]) mregs[idx][8*k +: 8] = data[8*k +: 8];
      if (idx == 0 && be[0] && data[0]) begin
        m_done = 1'b1;
        m_exit = data[63:1];
      end
      cons_exp = (idx == 1) && be[0];
    end
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, ".hold"}, 64'(wr_resp_valid_o), 64'd1);
    end
    chk({tag, ".wvld"}, 64'(wr_resp_valid_o), 64'd1);
    chk({tag, ".wid"}, 64'(wr_resp_id_o), 64'(id));
    chk({tag, ".werr"}, 64'({wr_resp_error_o, wr_resp_is_atomic_o}),
        64'({bad, cmd == 2'd2}));
    wr_resp_ready_i = 1'b1;
    step();
    wr_resp_ready_i = 1'b0;
    step();
    chk({tag, ".ncons"}, 64'(cons_cnt - c0), 64'(cons_exp));
    if (cons_exp) chk({tag, ".cbyte"}, 64'(cons_byte), 64'(data[7:0]));
    chk({tag, ".done"}, 64'(test_done_o), 64'(m_done));
    chk({tag, ".exit"}, 64'(exit_code_o), 64'(m_exit));
  endtask

  initial begin
    logic [39:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  cmd;
    int          beats;
    m_reset();
    repeat (3) step();
    chk("rst.valid", 64'({rd_resp_valid_o, wr_resp_valid_o}), 64'd0);
    chk("rst.side", 64'({test_done_o, console_valid_o, wr_data_ready_o}),
        64'd0);
    tb_rstn = 1'b1;
    step();
`ifndef UC_MMIO_RAND_STALL_EN
    chk("rst.rdy", 64'({rd_req_ready_o, wr_req_ready_o}), 64'd3);
`endif

    wr_txn(BASE + 40'h10, 0, 3, 1, 4'd3, 64'h0000_0000_DEAD_BEEF,
           8'hFF, 1, 0, "deadbeef");
    rd_txn(BASE + 40'h10, 0, 3, 0, 4'd3, 0, "rd_beef");
    chk("beef.abs", rd_resp_data_o, 64'h0000_0000_DEAD_BEEF);
    wr_txn(BASE + 40'h18, 0, 3, 1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF,
           8'h0F, 1, 1, "be0f");
    rd_txn(BASE + 40'h18, 0, 3, 0, 4'd2, 0, "rd_be0f");
    chk("be0f.abs", rd_resp_data_o, 64'h0000_0000_FFFF_FFFF);
    wr_txn(BASE, 0, 3, 1, 4'd4, 64'h15, 8'hFF, 1, 0, "tohost");
    chk("tohost.abs", 64'({test_done_o, exit_code_o}),
        64'({1'b1, 63'hA}));
    wr_txn(BASE, 0, 3, 1, 4'd5, 64'h0, 8'hFF, 1, 0, "tohost0");
    wr_txn(BASE + 40'h8, 0, 3, 1, 4'd6, 64'h41, 8'hFF, 1, 0, "console");
    chk("console.abs", 64'(cons_byte), 64'h41);
    rd_txn(BASE + 40'h40, 0, 3, 0, 4'd7, 0, "oow");
    rd_txn(BASE + 40'h10, 8'd1, 3, 0, 4'd8, 0, "len1");
    wr_txn(BASE + 40'h20, 0, 3, 2, 4'd9, 64'h1234, 8'hFF, 1, 0, "atomic");
    rd_txn(BASE + 40'h20, 0, 3, 0, 4'd10, 0, "rd_atomic");
    wr_txn(BASE + 40'h28, 0, 3, 1, 4'd11, 64'h77, 8'hFF, 2, 0, "twobeat");
    rd_txn(BASE + 40'h10, 0, 3, 0, 4'd12, 5, "hold5");

    // reset while a read is in flight
    rd_req_addr_i    = BASE + 40'h10;
    rd_req_len_i     = 0;
    rd_req_size_i    = 3;
    rd_req_command_i = 0;
    rd_req_valid_i   = 1'b1;
    while (!rd_req_ready_o) step();
    step();
    rd_req_valid_i = 1'b0;
    tb_rstn = 1'b0;
    step();
    chk("midrst", 64'({rd_resp_valid_o, test_done_o}), 64'd0);
    tb_rstn = 1'b1;
    m_reset();
    step();
    rd_txn(BASE + 40'h10, 0, 3, 0, 4'd1, 0, "postrst");

    for (int i = 0; i < N_RAND; i++) begin
      size = 3'($urandom_range(0, 4));
      a = BASE + 40'(8 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a + 40'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = a + 40'd64;
      len = ($urandom_range(0, 15) == 0) ? 8'd1 : 8'd0;
      if ($urandom_range(1, 0) == 1) begin
        cmd = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'd1;
        beats = ($urandom_range(0, 15) == 0) ? 2 : 1;
        wr_txn(a, len, size, cmd, 4'($urandom), {$urandom, $urandom},
               8'($urandom), beats, $urandom_range(0, 3), "rnd_wr");
      end else begin
        cmd = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'd0;
        rd_txn(a, len, size, cmd, 4'($urandom), $urandom_range(0, 3),
               "rnd_rd");
      end
    end
    for (int i = 0; i < 8; i++)
      rd_txn(BASE + 40'(8 * i), 0, 3, 0, 4'(i), 0, "final");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
